// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill path: responder FSM states,
// address field widths and the line-base alignment helper.
package cache_pkg;

  // Bits [1:0] of a byte address select the byte within a 32-bit word.
  localparam int unsigned OFFSET_W = 32'd2;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  // Width of an index over n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

  // Clear the word-in-line bits of a word index to get the line base.
  function automatic logic [31:0] line_base(input logic [31:0] word_idx,
                                            input int unsigned idx_w);
    return (word_idx >> idx_w) << idx_w;
  endfunction

endpackage

// File: rtl/refill_ram.sv
// Backing-store RAM: one synchronous write port for preload and one
// synchronous read port whose output register is the beat data register.
// A write to the address being read at the same edge is forwarded, so a
// beat always reflects the newest contents at the moment it is loaded.
module refill_ram
  import cache_pkg::*;
#(
  parameter int unsigned DEPTH  = 32'd256,
  parameter int unsigned DATA_W = 32'd32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [idx_width(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  input  logic [idx_width(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]           rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Storage array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next read-register value: hold unless a read is requested, forward a colliding write.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[rd_addr];
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read output register, cleared by reset so the beat data starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cache_refill_responder.sv
// Memory-side responder for the direct-mapped cache miss/refill interface.
// Accepts one line request at a time, waits a fixed latency, then returns
// the line as WORDS_PER_LINE beats starting at word 0 of the line.
module cache_refill_responder
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32'd32,
  parameter int unsigned DATA_W         = 32'd32,
  parameter int unsigned WORDS_PER_LINE = 32'd4,
  parameter int unsigned LATENCY        = 32'd3,
  parameter int unsigned MEM_DEPTH      = 32'd256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [ADDR_W-1:0]                    req_addr,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [DATA_W-1:0]                    rsp_data,
  output logic [idx_width(WORDS_PER_LINE)-1:0] rsp_idx,
  output logic                                 rsp_last,
  input  logic                                 wr_en,
  input  logic [idx_width(MEM_DEPTH)-1:0]      wr_addr,
  input  logic [DATA_W-1:0]                    wr_data
);

  localparam int unsigned IDX_W = idx_width(WORDS_PER_LINE);
  localparam int unsigned MEM_W = idx_width(MEM_DEPTH);
  localparam int unsigned CNT_W = idx_width(LATENCY);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MEM_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic               rd_en_s;
  logic [MEM_W-1:0]   rd_addr_s;
  logic [MEM_W-1:0]   word_idx_s;
  logic [MEM_W-1:0]   req_base_s;
  logic [IDX_W-1:0]   idx_inc_s;
  logic               addr_unused_s;

  // Upper address bits alias onto the RAM; byte-offset bits are irrelevant.
  assign word_idx_s    = req_addr[OFFSET_W +: MEM_W];
  assign req_base_s    = MEM_W'(line_base(32'(word_idx_s), IDX_W));
  assign idx_inc_s     = idx_q + IDX_W'(1);
  assign addr_unused_s = ^{req_addr[ADDR_W-1:OFFSET_W+MEM_W], req_addr[OFFSET_W-1:0]};

  // Next-state, counter, beat-register and RAM-read decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    last_d    = last_q;
    rd_en_s   = 1'b0;
    rd_addr_s = base_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          base_d = req_base_s;
          idx_d  = {IDX_W{1'b0}};
          last_d = 1'b0;
          if (LATENCY == 32'd1) begin
            // First beat is read at the accepting edge itself.
            state_d   = ST_BURST;
            valid_d   = 1'b1;
            rd_en_s   = 1'b1;
            rd_addr_s = req_base_s;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 32'd1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          // Counter reaches zero on this edge: present word 0 of the line.
          state_d   = ST_BURST;
          cnt_d     = {CNT_W{1'b0}};
          valid_d   = 1'b1;
          rd_en_s   = 1'b1;
          rd_addr_s = base_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BURST: begin
        if (rsp_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            // Load the next beat; the line base has its low bits cleared.
            idx_d     = idx_inc_s;
            last_d    = (idx_inc_s == IDX_W'(WORDS_PER_LINE - 32'd1));
            rd_en_s   = 1'b1;
            rd_addr_s = {base_q[MEM_W-1:IDX_W], idx_inc_s};
          end
        end else begin
          // Backpressure: every beat register holds.
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        idx_d   = {IDX_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control and beat registers; reset aborts any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      base_q  <= {MEM_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  refill_ram #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rsp_data)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = valid_q;
  assign rsp_idx   = idx_q;
  assign rsp_last  = last_q;

endmodule

// File: tb/tb_cache_refill_responder.sv
// Directed bench for cache_refill_responder: a table of line requests with
// hand-computed beats, plus sequences for backpressure, busy requests,
// preload visibility during a burst and reset in the middle of a burst.
module tb_cache_refill_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_idx;
  logic        rsp_last;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]      addr;
    logic [3:0][31:0] exp;
    string            nm;
  } vec_t;

  vec_t vecs[6];

  localparam logic [3:0][31:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [3:0][31:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

  cache_refill_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_idx   (rsp_idx),
    .rsp_last  (rsp_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Issue a request and wait for the first beat; ends on the first-beat negedge.
  task automatic issue(input logic [31:0] addr, input bit hold, input string nm);
    int n;
    @(negedge clk);
    check({nm, " ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = 1'b1;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      check({nm, " ready_wait"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 32'(n), 32'd3);
  endtask

  // Consume beats from the current negedge, optionally stalling one beat.
  task automatic collect(input logic [3:0][31:0] exp, input int stall_idx,
                         input int stall_n, input string nm);
    int beats;
    int stalls;
    int guard;
    beats  = 0;
    stalls = stall_n;
    guard  = 0;
    while (rsp_valid && beats < 4 && guard < 40) begin
      check({nm, " data"}, rsp_data, exp[beats]);
      check({nm, " idx"}, 32'(rsp_idx), 32'(beats));
      check({nm, " last"}, 32'(rsp_last), (beats == 3) ? 32'd1 : 32'd0);
      check({nm, " ready_burst"}, 32'(req_ready), 32'd0);
      if (beats == stall_idx && stalls > 0) begin
        rsp_ready = 1'b0;
        stalls--;
      end else begin
        rsp_ready = 1'b1;
        beats++;
      end
      guard++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check({nm, " beats"}, 32'(beats), 32'd4);
    check({nm, " valid_after"}, 32'(rsp_valid), 32'd0);
    check({nm, " ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    rsp_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 8'h0;
    wr_data   = 32'h0;

    // Reset state.
    #3;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst valid", 32'(rsp_valid), 32'd0);
    check("rst data", rsp_data, 32'h0);
    check("rst idx", 32'(rsp_idx), 32'd0);
    check("rst last", 32'(rsp_last), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst no_beat", 32'(rsp_valid), 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      preload(8'(4 + i), LINE_A[i]);
      preload(8'(132 + i), LINE_B[i]);
    end

    vecs[0] = '{32'h0000_0014, LINE_A, "basic"};
    vecs[1] = '{32'h0000_0216, LINE_B, "conflict_b"};
    vecs[2] = '{32'h0000_0016, LINE_A, "conflict_a"};
    vecs[3] = '{32'h0000_0410, LINE_A, "alias"};
    vecs[4] = '{32'h0000_021C, LINE_B, "b_last_word"};
    vecs[5] = '{32'hFFFF_FC13, LINE_A, "alias_high"};

    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].addr, 1'b0, vecs[v].nm);
      collect(vecs[v].exp, -1, 0, vecs[v].nm);
    end

    // Backpressure: beat 1 stalled for two cycles.
    issue(32'h14, 1'b0, "bp");
    collect(LINE_A, 1, 2, "bp");

    // Busy: request held through WAIT/BURST yields exactly one burst.
    issue(32'h410, 1'b1, "busy");
    collect(LINE_A, -1, 0, "busy");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busy no_second", 32'(rsp_valid), 32'd0);
    end

    // Preload during a refill: unpresented word updates, presented beat holds.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h14;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 8'd6;
    wr_data   = 32'hC2;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("wr first_valid", 32'(rsp_valid), 32'd1);
    check("wr first_data", rsp_data, 32'hA0);
    wr_en   = 1'b1;
    wr_addr = 8'd4;
    wr_data = 32'hC0;
    @(negedge clk);
    wr_en = 1'b0;
    check("wr held_data", rsp_data, 32'hA0);
    check("wr held_idx", 32'(rsp_idx), 32'd0);
    collect({32'hA3, 32'hC2, 32'hA1, 32'hA0}, -1, 0, "wr");
    preload(8'd4, 32'hA0);
    preload(8'd6, 32'hA2);

    // Reset after beat 1 aborts the burst; a new request starts from idx 0.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h14;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(rsp_valid && rsp_idx == 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst reached_beat1", 32'(rsp_data), 32'hA1);
    #2 rst = 1'b1;
    #1;
    check("midrst valid", 32'(rsp_valid), 32'd0);
    check("midrst data", rsp_data, 32'h0);
    check("midrst ready", 32'(req_ready), 32'd1);
    check("midrst idx", 32'(rsp_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst no_beat", 32'(rsp_valid), 32'd0);
    end
    issue(32'h14, 1'b0, "after_rst");
    collect(LINE_A, -1, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_refill_responder.md
# cache_refill_responder

Memory-side responder for the direct-mapped cache: it accepts a line-refill request issued by the cache controller on a miss and returns the addressed cache line as a burst of words after a fixed access latency. It models the backing store (word-addressed RAM with a preload write port) and is the other end of the cache's miss/refill interface. It is used both as the simulation backing memory and as the reference responder when verifying the cache's refill path.

## Interface

- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- WORDS_PER_LINE, 4, words per cache line (power of 2, ≥2)
- LATENCY, 3, cycles from request accept to first beat (≥1)
- MEM_DEPTH, 256, RAM depth in words (power of 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  refill request present
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_W  byte address of any byte in the missed line
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  cache accepts beat
- rsp_data  out  DATA_W  beat data
- rsp_idx  out  log2(WORDS_PER_LINE)  word index within line of current beat
- rsp_last  out  1  final beat of line
- wr_en  in  1  preload write strobe
- wr_addr  in  log2(MEM_DEPTH)  preload word address
- wr_data  in  DATA_W  preload data

## Operation

- Byte addressing: bits [1:0] byte offset, next log2(WORDS_PER_LINE) bits word-in-line; word index = req_addr[ADDR_W-1:2] mod MEM_DEPTH (upper bits alias).
- Line base word = word index with word-in-line bits cleared; beats always start at word 0 of the line (no critical-word-first) and run idx 0..WORDS_PER_LINE-1.
- FSM states: IDLE, WAIT, BURST.
  - IDLE: req_ready=1. req_valid&req_ready at an edge latches line base; goes to WAIT with counter = LATENCY-1, or directly to BURST if LATENCY=1.
  - WAIT: req_ready=0, rsp_valid=0; counter decrements each cycle; at 0 → BURST.
  - BURST: rsp_valid=1; idx advances on rsp_valid&rsp_ready; rsp_last=1 when idx=WORDS_PER_LINE-1; handshake of last beat → IDLE.
- req_valid outside IDLE is ignored (not queued).
- Backpressure: while rsp_valid&!rsp_ready, rsp_data/rsp_idx/rsp_last held stable.
- Preload write: wr_en at an edge writes RAM in any state. Write to a word not yet presented in the active burst is visible in that beat; beat already presented keeps its registered value.
- Reset: state IDLE, rsp_valid=0, rsp_last=0, rsp_idx=0, rsp_data=0, counter=0; req_ready=1 while rst asserted and after. RAM contents not cleared. Reset mid-WAIT/BURST aborts the burst with no further beats.

## Timing

- Accept at edge E0 → rsp_valid first high in cycle after edge E0+LATENCY-1 (i.e. LATENCY cycles after accept with LATENCY=1 meaning next cycle).
- rsp_ready held high: one beat per cycle, WORDS_PER_LINE consecutive cycles.
- req_ready high in cycle after last-beat handshake; minimum accept-to-accept spacing LATENCY+WORDS_PER_LINE cycles.
- All outputs registered except req_ready (decoded from state register only); no combinational path from inputs to outputs.

## Structure

- Shared package cache_pkg: state enum (IDLE/WAIT/BURST), OFFSET_W=2, derived INDEX/word-in-line widths, line-base alignment function.
- One sub-module: refill_ram (MEM_DEPTH×DATA_W, one synchronous write port, one synchronous read port); FSM, counter and beat registers in top level.

## Test plan

- Reset: assert rst mid-cycle → req_ready=1, rsp_valid=0, rsp_data=0 immediately; release, no spurious beats.
- Basic refill: preload words 4..7 = 0xA0..0xA3, request 0x14, rsp_ready=1 → beats 0xA0,0xA1,0xA2,0xA3, idx 0..3, rsp_last on 4th, first beat 3 cycles after accept.
- Conflict line: preload words 132..135 = 0xB0..0xB3, request 0x216 then 0x16 → first burst 0xB0..0xB3, second 0xA0..0xA3.
- Backpressure: rsp_ready low 2 cycles on beat idx 1 → rsp_data=0xA1 held, then 0xA2, 0xA3; total beats still 4.
- Aliasing/busy: request 0x410 → words 4..7 (0xA0..0xA3); req_valid held during WAIT/BURST → req_ready=0, exactly one burst.
- Reset mid-burst: rst after beat 1 → rsp_valid=0 at once; new request 0x14 returns full 4-beat line from idx 0.
